// File: rtl/ir_convolver_if.sv
// Sample stream bundle for ir_convolver: input handshake (in_*) and output handshake (out_*).
// master = upstream/downstream side, slave = the convolver itself.
interface ir_convolver_if #(
  parameter int DATA_W = 16
) ();
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/ir_convolver.sv
// Cabinet-IR convolver: one time-multiplexed MAC over TAPS cycles per sample, saturated output.
// Optional macro IR_CONV_ROUND_EN selects round-half-up instead of floor before saturation.
module ir_convolver #(
  parameter int TAPS     = 256,
  parameter int DATA_W   = 16,
  parameter int WEIGHT_W = 16,
  parameter int FRAC_W   = 15
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [TAPS-1:0][WEIGHT_W-1:0]    weights,
  ir_convolver_if.slave                    io
);

  localparam int PTR_W  = $clog2(TAPS);
  localparam int PROD_W = DATA_W + WEIGHT_W;
  localparam int ACC_W  = PROD_W + PTR_W;

  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_IDLE  = 3'd1,
    ST_MAC   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

  state_t                    state_r;
  logic [PTR_W-1:0]          wr_ptr_r;
  logic [PTR_W-1:0]          clr_cnt_r;
  logic [PTR_W-1:0]          base_r;
  logic [PTR_W-1:0]          k_r;
  logic signed [ACC_W-1:0]   acc_r;
  logic signed [PROD_W-1:0]  prod_r;
  logic                      in_ready_r;
  logic                      out_valid_r;
  logic [DATA_W-1:0]         out_data_r;

  // History buffer: deliberately unreset so it maps onto RAM; CLEAR zeroes it instead.
  logic [DATA_W-1:0]         mem_r [TAPS];

  logic                      accept_s;
  logic [PTR_W-1:0]          rd_addr_s;
  logic [DATA_W-1:0]         rd_data_s;
  logic signed [PROD_W-1:0]  prod_s;
  logic signed [ACC_W-1:0]   prod_ext_s;
  logic signed [ACC_W-1:0]   rnd_s;
  logic signed [ACC_W-1:0]   acc_fin_s;
  logic signed [ACC_W-1:0]   shifted_s;
  logic [DATA_W-1:0]         sat_s;
  logic                      mem_we_s;
  logic [PTR_W-1:0]          mem_wa_s;
  logic [DATA_W-1:0]         mem_wd_s;

  function automatic logic [DATA_W-1:0] sat_fn(input logic signed [ACC_W-1:0] v);
    logic [DATA_W-1:0] r;
    // In range when every bit above the output sign bit matches it.
    if ((&v[ACC_W-1:DATA_W-1]) || !(|v[ACC_W-1:DATA_W-1])) begin
      r = v[DATA_W-1:0];
    end else if (v[ACC_W-1]) begin
      r = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      r = {1'b0, {(DATA_W-1){1'b1}}};
    end
    return r;
  endfunction

`ifdef IR_CONV_ROUND_EN
  assign rnd_s = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC_W-1);
`else
  assign rnd_s = '0;
`endif

  assign accept_s   = io.in_valid && in_ready_r && (state_r == ST_IDLE);
  assign rd_addr_s  = base_r - k_r;
  assign rd_data_s  = mem_r[rd_addr_s];
  assign prod_s     = $signed(rd_data_s) * $signed(weights[k_r]);
  assign prod_ext_s = {{PTR_W{prod_r[PROD_W-1]}}, prod_r};
  assign acc_fin_s  = acc_r + prod_ext_s + rnd_s;
  assign shifted_s  = acc_fin_s >>> FRAC_W;
  assign sat_s      = sat_fn(shifted_s);

  assign io.in_ready  = in_ready_r;
  assign io.out_valid = out_valid_r;
  assign io.out_data  = out_data_r;

  // Buffer write port: zero sweep during CLEAR, sample write on input handshake.
  always_comb begin
    mem_we_s = 1'b0;
    mem_wa_s = wr_ptr_r;
    mem_wd_s = io.in_data;
    case (state_r)
      ST_CLEAR: begin
        mem_we_s = 1'b1;
        mem_wa_s = clr_cnt_r;
        mem_wd_s = '0;
      end
      ST_IDLE: begin
        if (accept_s) begin
          mem_we_s = 1'b1;
        end else begin
          mem_we_s = 1'b0;
        end
      end
      default: begin
        mem_we_s = 1'b0;
      end
    endcase
  end

  // History buffer storage.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_wa_s] <= mem_wd_s;
    end
  end

  // Control FSM, MAC datapath and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_CLEAR;
      wr_ptr_r    <= '0;
      clr_cnt_r   <= '0;
      base_r      <= '0;
      k_r         <= '0;
      acc_r       <= '0;
      prod_r      <= '0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          clr_cnt_r <= clr_cnt_r + 1'b1;
          if (clr_cnt_r == PTR_W'(TAPS-1)) begin
            state_r    <= ST_IDLE;
            in_ready_r <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (accept_s) begin
            base_r     <= wr_ptr_r;
            wr_ptr_r   <= wr_ptr_r + 1'b1;
            acc_r      <= '0;
            prod_r     <= '0;
            k_r        <= '0;
            in_ready_r <= 1'b0;
            state_r    <= ST_MAC;
          end
        end
        ST_MAC: begin
          // prod_r lags by one tap; it is zero on the first MAC cycle.
          prod_r <= prod_s;
          acc_r  <= acc_r + prod_ext_s;
          k_r    <= k_r + 1'b1;
          if (k_r == PTR_W'(TAPS-1)) begin
            state_r <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          acc_r       <= acc_r + prod_ext_s;
          out_data_r  <= sat_s;
          out_valid_r <= 1'b1;
          state_r     <= ST_OUT;
        end
        ST_OUT: begin
          if (io.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          state_r     <= ST_CLEAR;
          clr_cnt_r   <= '0;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ir_convolver.sv
// Randomized self-checking bench for ir_convolver against a direct-form convolution model.
module tb_ir_convolver;
  localparam int TAPS     = 32;
  localparam int DATA_W   = 16;
  localparam int WEIGHT_W = 16;
  localparam int FRAC_W   = 15;
`ifdef IR_CONV_ROUND_EN
  localparam logic [15:0] W0_EXP = 16'h028D;
  localparam logic [15:0] W1_EXP = 16'h058A;
`else
  localparam logic [15:0] W0_EXP = 16'h028C;
  localparam logic [15:0] W1_EXP = 16'h0589;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [TAPS-1:0][WEIGHT_W-1:0] weights;
  logic [TAPS-1:0][WEIGHT_W-1:0] orig_w;

  ir_convolver_if #(.DATA_W(DATA_W)) bus ();

  ir_convolver #(.TAPS(TAPS), .DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W), .FRAC_W(FRAC_W)) dut (
    .clk(clk), .rst(rst), .weights(weights), .io(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int hist[$];  // newest sample first; empty entries count as zero history

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] model_out();
    longint s = 0;
    for (int k = 0; k < TAPS && k < hist.size(); k++)
      s += longint'($signed(weights[k])) * longint'(hist[k]);
`ifdef IR_CONV_ROUND_EN
    s += longint'(1) << (FRAC_W-1);
`endif
    s = s >>> FRAC_W;
    if (s > 32767) return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return s[15:0];
  endfunction

  task automatic push_hist(input logic [15:0] d);
    hist.push_front(int'($signed(d)));
    while (hist.size() > TAPS) void'(hist.pop_back());
  endtask

  // Drives one sample (entered and left at a negedge); returns first valid output and latency in cycles.
  task automatic run_sample(input logic [15:0] d, output logic [15:0] got, output int lat, output bit to);
    int w = 0;
    to = 1'b0; lat = 0; got = '0;
    while (!bus.in_ready && w < 3*TAPS) begin @(negedge clk); w++; end
    if (!bus.in_ready) begin
      to = 1'b1;
    end else begin
      bus.in_valid = 1'b1; bus.in_data = d;
      @(posedge clk);
      push_hist(d);
      @(negedge clk);
      bus.in_valid = 1'b0; bus.in_data = '0;
      lat = 1;
      while (!bus.out_valid && lat < TAPS+20) begin @(negedge clk); lat++; end
      if (!bus.out_valid) to = 1'b1;
      got = bus.out_data;
    end
  endtask

  task automatic test_reset();
    int cnt = 0;
    logic [15:0] got; int lat; bit to;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_data} !== 18'h0)
      $display("FAIL reset_outputs: got rdy=%b vld=%b data=%h, required 0/0/0000", bus.in_ready, bus.out_valid, bus.out_data);
    else n_pass++;
    rst = 1'b0; hist.delete();
    while (!bus.in_ready && cnt < 3*TAPS) begin @(negedge clk); cnt++; end
    n_checks++;
    if (cnt !== TAPS) $display("FAIL clear_length: in_ready after %0d cycles, required %0d", cnt, TAPS);
    else n_pass++;
    run_sample(16'h0000, got, lat, to);
    n_checks++;
    if (to || got !== 16'h0000) $display("FAIL first_zero: got %h timeout=%0b, required 0000", got, to);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_impulse();
    logic [15:0] got, d; int lat; bit to;
    for (int i = 0; i < 6; i++) begin
      d = (i == 0) ? 16'h4000 : 16'h0000;
      run_sample(d, got, lat, to);
      n_checks++;
      if (to || lat !== TAPS+2) $display("FAIL impulse_latency[%0d]: got %0d, required %0d", i, lat, TAPS+2);
      else n_pass++;
      n_checks++;
      if (got !== model_out()) $display("FAIL impulse_model[%0d]: got %h, required %h", i, got, model_out());
      else n_pass++;
      if (i < 2) begin
        n_checks++;
        if (got !== ((i == 0) ? W0_EXP : W1_EXP))
          $display("FAIL impulse_const[%0d]: got %h, required %h", i, got, (i == 0) ? W0_EXP : W1_EXP);
        else n_pass++;
      end
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
        $display("FAIL back_to_back[%0d]: got vld=%b rdy=%b, required 0/1", i, bus.out_valid, bus.in_ready);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [15:0] got, d; int lat; bit to;
    for (int i = 0; i < 12; i++) begin
      d = 16'($urandom);
      run_sample(d, got, lat, to);
      n_checks++;
      if (to || got !== model_out() || lat !== TAPS+2)
        $display("FAIL random[%0d]: got %h lat %0d, required %h lat %0d", i, got, lat, model_out(), TAPS+2);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] got, exp; int lat; bit to;
    bus.out_ready = 1'b0;
    run_sample(16'($urandom), got, lat, to);
    exp = model_out();
    n_checks++;
    if (to || got !== exp) $display("FAIL bp_value: got %h, required %h", got, exp);
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = i[0]; bus.in_data = 16'($urandom);
      @(negedge clk);
      n_checks++;
      if ({bus.out_valid, bus.in_ready, bus.out_data} !== {1'b1, 1'b0, exp})
        $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b data=%h, required 1/0/%h", i, bus.out_valid, bus.in_ready, bus.out_data, exp);
      else n_pass++;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL bp_release: got vld=%b rdy=%b, required 0/1", bus.out_valid, bus.in_ready);
    else n_pass++;
    run_sample(16'($urandom), got, lat, to);
    n_checks++;
    if (to || got !== model_out()) $display("FAIL bp_after: got %h, required %h", got, model_out());
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_saturation();
    logic [15:0] got; int lat; bit to;
    logic [15:0] pat [2];
    pat[0] = 16'h7FFF; pat[1] = 16'h8000;
    for (int k = 0; k < TAPS; k++) weights[k] = 16'h7FFF;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < TAPS; i++) begin
        run_sample(pat[p], got, lat, to);
        n_checks++;
        if (to || got !== model_out()) $display("FAIL sat_model[%0d][%0d]: got %h, required %h", p, i, got, model_out());
        else n_pass++;
        @(negedge clk);
      end
      n_checks++;
      if (got !== pat[p]) $display("FAIL sat_final[%0d]: got %h, required %h", p, got, pat[p]);
      else n_pass++;
    end
    weights = orig_w;
  endtask

  task automatic test_wrap();
    logic [15:0] got, d; int lat; bit to;
    for (int i = 0; i < 4*TAPS + 2; i++) begin
      d = (i >= TAPS && (i % TAPS) == 0) ? 16'h4000 : 16'h0000;
      run_sample(d, got, lat, to);
      n_checks++;
      if (to || got !== model_out()) $display("FAIL wrap_model[%0d]: got %h, required %h", i, got, model_out());
      else n_pass++;
      if (i >= TAPS && (i % TAPS) == 0) begin
        n_checks++;
        if (got !== W0_EXP) $display("FAIL wrap_w0[%0d]: got %h, required %h", i, got, W0_EXP);
        else n_pass++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] got; int lat; bit to;
    bus.out_ready = 1'b0;
    run_sample(16'h1234, got, lat, to);
    rst = 1'b1; hist.delete();
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0000)
      $display("FAIL reset_at_out: got vld=%b data=%h, required 0/0000", bus.out_valid, bus.out_data);
    else n_pass++;
    @(negedge clk); rst = 1'b0; bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_sample(16'($urandom_range(16'h7FFF, 16'h1000)), got, lat, to);
      @(negedge clk);
    end
    while (!bus.in_ready) @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = 16'h5555;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (TAPS/2) @(negedge clk);
    rst = 1'b1; hist.delete();
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0)
      $display("FAIL reset_mid_mac: got vld=%b rdy=%b, required 0/0", bus.out_valid, bus.in_ready);
    else n_pass++;
    @(negedge clk); rst = 1'b0;
    run_sample(16'h4000, got, lat, to);
    n_checks++;
    if (to || got !== W0_EXP) $display("FAIL reset_no_residue: got %h, required %h", got, W0_EXP);
    else n_pass++;
    n_checks++;
    if (got !== model_out()) $display("FAIL reset_model: got %h, required %h", got, model_out());
    else n_pass++;
    @(negedge clk);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    for (int k = 0; k < TAPS; k++) weights[k] = 16'($urandom);
    weights[0] = 16'h0519;
    weights[1] = 16'h0B13;
    orig_w = weights;
    @(negedge clk);
    test_reset();
    test_impulse();
    test_random();
    test_backpressure();
    test_saturation();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
